// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the sequential 2-bit-slice multiplier.
package mult_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of slice-pair products needed for a WIDTH x WIDTH multiply.
  function automatic int steps_f(input int width);
    return (width / 2) * (width / 2);
  endfunction

  // Step counter width; kept at least one bit so WIDTH=2 still elaborates.
  function automatic int cnt_w_f(input int width);
    int s;
    s = steps_f(width);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

  // Shift amount width; largest shift is 2*WIDTH-4.
  function automatic int shift_w_f(input int width);
    return $clog2(2 * width);
  endfunction

  // Slice index width for selecting one of WIDTH/2 two-bit slices.
  function automatic int idx_w_f(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/mult_seq_acc.sv
// Shift-and-add accumulator for partial products of the 2-bit-slice multiplier.
module mult_seq_acc
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SHIFT_W = shift_w_f(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [3:0]           pp,
  input  logic [SHIFT_W-1:0]   shift,
  output logic [2*WIDTH-1:0]   acc
);

  localparam int AW = 2 * WIDTH;

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [AW-1:0] pp_ext;

  always_comb begin
    pp_ext = AW'(pp);
    acc_d  = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = acc_q + (pp_ext << shift);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/multiplier_2bit.sv
// Combinational 2x2 unsigned multiplier shared by the sequencer.
module multiplier_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] res
);

  assign res = {2'b00, a} * {2'b00, b};

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer computing a WIDTH x WIDTH unsigned product one 2-bit slice pair
// per cycle through an external multiplier_2bit.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           mul_a,
  output logic [1:0]           mul_b,
  input  logic [3:0]           mul_res
);

  localparam int HALF    = WIDTH / 2;
  localparam int STEPS   = steps_f(WIDTH);
  localparam int CNT_W   = cnt_w_f(WIDTH);
  localparam int SHIFT_W = shift_w_f(WIDTH);
  localparam int IDX_W   = idx_w_f(WIDTH);
  localparam int PW      = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [PW-1:0]      product_q, product_d;

  logic               acc_clear;
  logic               acc_en;
  logic [PW-1:0]      acc;
  logic [IDX_W-1:0]   i_sel;
  logic [IDX_W-1:0]   j_sel;
  logic [SHIFT_W-1:0] shift;

  logic [1:0] a_slice [HALF];
  logic [1:0] b_slice [HALF];

  for (genvar gi = 0; gi < HALF; gi++) begin : g_slice
    assign a_slice[gi] = a_q[2*gi +: 2];
    assign b_slice[gi] = b_q[2*gi +: 2];
  end

  // Step k walks a-slices in the outer position and b-slices in the inner.
  always_comb begin
    i_sel = IDX_W'(int'(step_q) / HALF);
    j_sel = IDX_W'(int'(step_q) % HALF);
    shift = SHIFT_W'(2 * (int'(i_sel) + int'(j_sel)));
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          step_d    = '0;
          acc_clear = 1'b1;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        acc_en = 1'b1;
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = ST_DONE;
        end else begin
          step_d = step_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        product_d = acc;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
    end
  end

  mult_seq_acc #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .enable (acc_en),
    .pp     (mul_res),
    .shift  (shift),
    .acc    (acc)
  );

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_MUL);
  assign done  = (state_q == ST_DONE);

  // The finished sum is already complete in DONE, so expose it that cycle.
  assign product = done ? acc : product_q;

  assign mul_a = busy ? a_slice[i_sel] : 2'b00;
  assign mul_b = busy ? b_slice[j_sel] : 2'b00;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl paired with multiplier_2bit.
module tb_mult_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int HALF  = WIDTH / 2;
  localparam int STEPS = HALF * HALF;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   a;
  logic [3:0]   b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [7:0]   product;
  logic [1:0]   mul_a;
  logic [1:0]   mul_b;
  logic [3:0]   mul_res;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_res (mul_res)
  );

  multiplier_2bit u_mul (
    .a   (mul_a),
    .b   (mul_b),
    .res (mul_res)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: cycles elapsed since accept (0 = idle), captured operands.
  int m_phase = 0;
  int m_cap_a = 0;
  int m_cap_b = 0;
  int m_prod  = 0;
  int done_seen = 0;
  int cyc = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle(input logic s, input logic [3:0] ai, input logic [3:0] bi, input logic r);
    int k;
    start = s;
    a     = ai;
    b     = bi;
    rst   = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_phase = 0;
      m_prod  = 0;
    end else if (m_phase == 0) begin
      if (s) begin
        m_phase = 1;
        m_cap_a = int'(ai);
        m_cap_b = int'(bi);
      end
    end else if (m_phase == STEPS + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
    if (m_phase == STEPS + 1) m_prod = m_cap_a * m_cap_b;
    #1;
    chk_eq("ready", 32'(ready), 32'(m_phase == 0));
    chk_eq("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= STEPS));
    chk_eq("done", 32'(done), 32'(m_phase == STEPS + 1));
    chk_eq("product", 32'(product), 32'(m_prod));
    if (m_phase >= 1 && m_phase <= STEPS) begin
      k = m_phase - 1;
      chk_eq("mul_a", 32'(mul_a), 32'((m_cap_a >> (2 * (k / HALF))) & 3));
      chk_eq("mul_b", 32'(mul_b), 32'((m_cap_b >> (2 * (k % HALF))) & 3));
    end else begin
      chk_eq("mul_a_idle", 32'(mul_a), 32'd0);
      chk_eq("mul_b_idle", 32'(mul_b), 32'd0);
    end
    if (done === 1'b1) done_seen++;
    $display("cyc=%0d rst=%0b start=%0b a=%0d b=%0d ready=%0b busy=%0b done=%0b product=%02h",
             cyc, r, s, ai, bi, ready, busy, done, product);
  endtask

  task automatic run_op(input string tag, input logic [3:0] ai, input logic [3:0] bi,
                        input logic [7:0] exp);
    int d0;
    d0 = done_seen;
    cycle(1'b1, ai, bi, 1'b0);
    for (int c = 0; c < STEPS + 2; c++) begin
      cycle(1'b0, 4'($urandom), 4'($urandom), 1'b0);
      if (c == STEPS) chk_eq({tag, "_product"}, 32'(product), 32'(exp));
    end
    chk_eq({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
  endtask

  initial begin
    int d0;
    int n;
    int exp_q[$];
    int last_done;
    int holds;
    logic [3:0] pa;
    logic [3:0] pb;

    // Reset
    cycle(1'b0, 4'd0, 4'd0, 1'b1);
    cycle(1'b1, 4'd7, 4'd7, 1'b1);
    chk_eq("rst_ready", 32'(ready), 32'd1);
    chk_eq("rst_product", 32'(product), 32'd0);

    // 3 x 5 with explicit latency checks
    d0 = done_seen;
    cycle(1'b1, 4'd3, 4'd5, 1'b0);
    chk_eq("a3b5_ready_low", 32'(ready), 32'd0);
    for (int c = 2; c <= STEPS + 1; c++) begin
      cycle(1'b0, 4'($urandom), 4'($urandom), 1'b0);
      if (c < STEPS + 1) chk_eq("a3b5_no_early_done", 32'(done), 32'd0);
    end
    chk_eq("a3b5_done_at_5", 32'(done), 32'd1);
    chk_eq("a3b5_product", 32'(product), 32'h0F);
    cycle(1'b0, 4'd0, 4'd0, 1'b0);
    chk_eq("a3b5_ready_after", 32'(ready), 32'd1);
    chk_eq("a3b5_product_held", 32'(product), 32'h0F);
    chk_eq("a3b5_done_count", 32'(done_seen - d0), 32'd1);

    run_op("a15b15", 4'd15, 4'd15, 8'hE1);
    run_op("a0b9", 4'd0, 4'd9, 8'h00);

    // Exhaustive back-to-back
    d0 = done_seen;
    n = 0;
    for (int t = 0; t < 256 * (STEPS + 2) + 20; t++) begin
      if (n == 256 && m_phase == 0) break;
      if (m_phase == 0 && n < 256) begin
        pa = 4'(n / 16);
        pb = 4'(n % 16);
        exp_q.push_back(n / 16 * (n % 16));
        n++;
        cycle(1'b1, pa, pb, 1'b0);
      end else begin
        cycle(1'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) chk_eq("exh_extra_done", 32'd1, 32'd0);
        else chk_eq("exh_product", 32'(product), 32'(exp_q.pop_front()));
      end
    end
    chk_eq("exh_done_count", 32'(done_seen - d0), 32'd256);
    chk_eq("exh_pending", 32'(exp_q.size()), 32'd0);

    // start pulsed during MUL is ignored
    d0 = done_seen;
    cycle(1'b1, 4'd7, 4'd6, 1'b0);
    cycle(1'b0, 4'd0, 4'd0, 1'b0);
    cycle(1'b1, 4'd1, 4'd1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 4'd1, 4'd1, 1'b0);
      if (c == 2) chk_eq("a7b6_product", 32'(product), 32'h2A);
    end
    chk_eq("a7b6_product_held", 32'(product), 32'h2A);
    chk_eq("a7b6_done_count", 32'(done_seen - d0), 32'd1);

    // Reset during step 2
    d0 = done_seen;
    cycle(1'b1, 4'd9, 4'd9, 1'b0);
    cycle(1'b0, 4'd9, 4'd9, 1'b0);
    cycle(1'b0, 4'd9, 4'd9, 1'b0);
    cycle(1'b0, 4'd9, 4'd9, 1'b1);
    chk_eq("abort_ready", 32'(ready), 32'd1);
    chk_eq("abort_product", 32'(product), 32'd0);
    chk_eq("abort_done", 32'(done), 32'd0);
    for (int c = 0; c < 6; c++) cycle(1'b0, 4'd9, 4'd9, 1'b0);
    chk_eq("abort_done_count", 32'(done_seen - d0), 32'd0);

    // start held high with fixed operands
    d0 = done_seen;
    last_done = -1;
    holds = 0;
    for (int c = 0; c < 5 * (STEPS + 2); c++) begin
      cycle(1'b1, 4'd2, 4'd3, 1'b0);
      if (done === 1'b1) begin
        chk_eq("hold_product", 32'(product), 32'h06);
        if (last_done < 0) chk_eq("hold_first_done", 32'(c), 32'(STEPS));
        else chk_eq("hold_interval", 32'(c - last_done), 32'(STEPS + 2));
        last_done = c;
        holds++;
      end
    end
    chk_eq("hold_done_count", 32'(holds), 32'd5);
    cycle(1'b0, 4'd0, 4'd0, 1'b0);

    // Random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
